// File: rtl/vram_arbiter.sv
// vram_arbiter: owns the single-port 2 KiB text RAM; video fetch has priority, CPU uses a req/ack FSM (video data at t+2, CPU ack at g+2).
// Optional CPU starvation guard (bounded by STARVE_LIMIT) is built when VRAM_ARB_STARVE_GUARD_EN is defined.
module vram_arbiter #(
    parameter int STARVE_LIMIT = 15
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        VID_REQ,
    input  logic [10:0] VID_A,
    output logic [7:0]  VID_DATA,
    output logic        VID_VALID,
    output logic        VID_MISS,
    input  logic        CPU_REQ,
    input  logic        CPU_WE,
    input  logic [10:0] CPU_A,
    input  logic [7:0]  CPU_WDATA,
    output logic [7:0]  CPU_RDATA,
    output logic        CPU_ACK,
    output logic [10:0] RAM_A,
    output logic        RAM_WE,
    output logic [7:0]  RAM_WDATA,
    input  logic [7:0]  RAM_RDATA
);

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : g_bad_limit
        $error("vram_arbiter: STARVE_LIMIT must be in 1..255");
    end

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANTED = 2'd1,
        ST_ACK     = 2'd2
    } cpu_state_t;

    cpu_state_t  state_q, state_d;
    logic        v1_q, v1_d;
    logic        v2_q, v2_d;
    logic [7:0]  vid_data_q, vid_data_d;
    logic [7:0]  cpu_rdata_q, cpu_rdata_d;

    logic        cpu_idle;
    logic        force_cpu;
    logic        cpu_gnt;
    logic        vid_gnt;

`ifdef VRAM_ARB_STARVE_GUARD_EN
    localparam logic [7:0] LIMIT_W = 8'(STARVE_LIMIT);

    logic [7:0]  wait_q, wait_d;
    logic        m1_q, m1_d;
    logic        m2_q, m2_d;
`endif

    // Grant decision; nothing is granted while RESET is high so the RAM never sees a write then.
    always_comb begin
        cpu_idle  = (state_q == ST_IDLE);
`ifdef VRAM_ARB_STARVE_GUARD_EN
        force_cpu = !RESET && cpu_idle && CPU_REQ && (wait_q == LIMIT_W);
`else
        force_cpu = 1'b0;
`endif
        cpu_gnt   = !RESET && cpu_idle && CPU_REQ && (!VID_REQ || force_cpu);
        vid_gnt   = !RESET && VID_REQ && !force_cpu;
    end

    always_comb begin
        RAM_A     = '0;
        RAM_WE    = 1'b0;
        RAM_WDATA = '0;
        if (cpu_gnt) begin
            RAM_A     = CPU_A;
            RAM_WE    = CPU_WE;
            RAM_WDATA = CPU_WDATA;
        end else if (vid_gnt) begin
            RAM_A     = VID_A;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (cpu_gnt) state_d = ST_GRANTED;
            ST_GRANTED: state_d = ST_ACK;
            ST_ACK:     state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase

        v1_d        = vid_gnt;
        v2_d        = v1_q;
        vid_data_d  = v1_q ? RAM_RDATA : vid_data_q;
        cpu_rdata_d = (state_q == ST_GRANTED) ? RAM_RDATA : cpu_rdata_q;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= ST_IDLE;
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            vid_data_q  <= '0;
            cpu_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            v1_q        <= v1_d;
            v2_q        <= v2_d;
            vid_data_q  <= vid_data_d;
            cpu_rdata_q <= cpu_rdata_d;
        end
    end

`ifdef VRAM_ARB_STARVE_GUARD_EN
    // Wait counter only moves while the CPU is eligible but loses to video; m1/m2 mirror v1/v2 for dropped video.
    always_comb begin
        wait_d = wait_q;
        if (cpu_gnt || !CPU_REQ) begin
            wait_d = '0;
        end else if (cpu_idle && (wait_q != LIMIT_W)) begin
            wait_d = wait_q + 8'd1;
        end
        m1_d = VID_REQ && force_cpu;
        m2_d = m1_q;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            wait_q <= '0;
            m1_q   <= 1'b0;
            m2_q   <= 1'b0;
        end else begin
            wait_q <= wait_d;
            m1_q   <= m1_d;
            m2_q   <= m2_d;
        end
    end

    assign VID_MISS = m2_q && !RESET;
`else
    assign VID_MISS = 1'b0;
`endif

    assign VID_VALID = v2_q && !RESET;
    assign VID_DATA  = RESET ? 8'h00 : vid_data_q;
    assign CPU_ACK   = (state_q == ST_ACK) && !RESET;
    assign CPU_RDATA = RESET ? 8'h00 : cpu_rdata_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Scoreboard bench for vram_arbiter: a cycle-level reference of the grant rules predicts every VID_VALID/VID_MISS/CPU_ACK.
module tb_vram_arbiter;
    localparam int LIMIT = 3;
`ifdef VRAM_ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    typedef struct {
        int         due;
        logic [7:0] dat;
        bit         wr;
    } ev_t;

    logic        CLK;
    logic        RESET;
    logic        VID_REQ;
    logic [10:0] VID_A;
    logic [7:0]  VID_DATA;
    logic        VID_VALID;
    logic        VID_MISS;
    logic        CPU_REQ;
    logic        CPU_WE;
    logic [10:0] CPU_A;
    logic [7:0]  CPU_WDATA;
    logic [7:0]  CPU_RDATA;
    logic        CPU_ACK;
    logic [10:0] RAM_A;
    logic        RAM_WE;
    logic [7:0]  RAM_WDATA;
    logic [7:0]  RAM_RDATA;

    vram_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .CLK(CLK), .RESET(RESET),
        .VID_REQ(VID_REQ), .VID_A(VID_A), .VID_DATA(VID_DATA),
        .VID_VALID(VID_VALID), .VID_MISS(VID_MISS),
        .CPU_REQ(CPU_REQ), .CPU_WE(CPU_WE), .CPU_A(CPU_A), .CPU_WDATA(CPU_WDATA),
        .CPU_RDATA(CPU_RDATA), .CPU_ACK(CPU_ACK),
        .RAM_A(RAM_A), .RAM_WE(RAM_WE), .RAM_WDATA(RAM_WDATA), .RAM_RDATA(RAM_RDATA)
    );

    int         cyc = 0;
    int         n_tests = 0;
    int         n_fail = 0;
    ev_t        vq[$];
    ev_t        cq[$];
    ev_t        mq[$];
    logic [7:0] mem [2048];
    logic [7:0] ref_mem [2048];

    bit         cm_active = 1'b0;
    bit         cm_we = 1'b0;
    logic [10:0] cm_a = '0;
    logic [7:0] cm_wd = '0;
    int         cm_ack_cyc = -1;
    int         next_ok = 0;
    int         wait_cnt = 0;

    logic [7:0] held = '0;
    logic [7:0] last_rdata = '0;
    int         last_ack = -1;
    int         prev_ack = -1;
    int         miss_cyc = -1;
    int         n_acks = 0;
    int         n_valid = 0;

    function automatic logic [7:0] init_val(input int i);
        return (i == 'h040) ? 8'h41 : 8'((i * 37 + 11) ^ (i >> 3));
    endfunction

    task automatic chk(input bit ok, input string name, input int act, input int exp);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always @(posedge CLK) cyc <= cyc + 1;

    // Behavioural RAM: synchronous read of the pre-write contents.
    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = init_val(i);
        RAM_RDATA = '0;
        forever begin
            @(posedge CLK);
            RAM_RDATA <= mem[RAM_A];
            if (RAM_WE) mem[RAM_A] = RAM_WDATA;
        end
    end

    always @(negedge CLK) begin : monitor
        bit  ev, ec, em;
        ev_t e;
        if (RESET) begin
            chk({VID_DATA, CPU_RDATA, VID_VALID, VID_MISS, CPU_ACK, RAM_WE, RAM_A} == '0,
                "reset_outputs", int'({VID_DATA, CPU_RDATA, VID_VALID, VID_MISS, CPU_ACK, RAM_WE}), 0);
            held = '0;
        end else begin
            ev = (vq.size() != 0) && (vq[0].due == cyc);
            chk(VID_VALID == ev, "vid_valid", int'(VID_VALID), int'(ev));
            if (ev) begin
                e = vq.pop_front();
                held = e.dat;
            end
            if (VID_VALID) n_valid++;
            chk(VID_DATA == held, "vid_data", int'(VID_DATA), int'(held));

            ec = (cq.size() != 0) && (cq[0].due == cyc);
            chk(CPU_ACK == ec, "cpu_ack", int'(CPU_ACK), int'(ec));
            if (ec) begin
                e = cq.pop_front();
                if (CPU_ACK && !e.wr) chk(CPU_RDATA == e.dat, "cpu_rdata", int'(CPU_RDATA), int'(e.dat));
            end
            if (CPU_ACK) begin
                prev_ack = last_ack;
                last_ack = cyc;
                last_rdata = CPU_RDATA;
                n_acks++;
            end

            em = (mq.size() != 0) && (mq[0].due == cyc);
            chk(VID_MISS == em, "vid_miss", int'(VID_MISS), int'(em));
            if (em) void'(mq.pop_front());
            if (VID_MISS) miss_cyc = cyc;
        end
    end

    // Reference: decides this cycle's grant from the arbitration rules and queues the responses due two cycles later.
    task automatic model_step(input int c, input bit v, input logic [10:0] va, input bit rst);
        bit  idle, frc, cg;
        ev_t e;
        if (rst) begin
            vq.delete();
            cq.delete();
            mq.delete();
            next_ok  = c + 1;
            wait_cnt = 0;
            return;
        end
        idle = (c >= next_ok);
        frc  = GUARD && idle && cm_active && (wait_cnt >= LIMIT);
        cg   = idle && cm_active && (!v || frc);
        if (cg) begin
            e.due = c + 2;
            e.wr  = cm_we;
            e.dat = ref_mem[cm_a];
            cq.push_back(e);
            if (cm_we) ref_mem[cm_a] = cm_wd;
            next_ok    = c + 3;
            cm_ack_cyc = c + 2;
        end
        if (v && !frc) begin
            e.due = c + 2;
            e.wr  = 1'b0;
            e.dat = ref_mem[va];
            vq.push_back(e);
        end
        if (v && frc) begin
            e.due = c + 2;
            e.wr  = 1'b0;
            e.dat = '0;
            mq.push_back(e);
        end
        if (cg || !cm_active) wait_cnt = 0;
        else if (idle && wait_cnt < LIMIT) wait_cnt++;
    endtask

    task automatic drive_cycle(input bit v, input logic [10:0] va, input bit rst,
                               input bit new_cpu, input bit nwe, input logic [10:0] na,
                               input logic [7:0] nwd);
        @(posedge CLK);
        #1;
        if (rst) begin
            cm_active  = 1'b0;
            cm_ack_cyc = -1;
        end else begin
            if (cm_active && cm_ack_cyc == cyc - 1) cm_active = 1'b0;
            if (!cm_active && new_cpu) begin
                cm_active  = 1'b1;
                cm_we      = nwe;
                cm_a       = na;
                cm_wd      = nwd;
                cm_ack_cyc = -1;
            end
        end
        RESET     = rst;
        VID_REQ   = v;
        VID_A     = va;
        CPU_REQ   = cm_active;
        CPU_WE    = cm_we;
        CPU_A     = cm_a;
        CPU_WDATA = cm_wd;
        model_step(cyc, v, va, rst);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) drive_cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    initial begin : main
        int s, base_acks, base_valid;
        for (int i = 0; i < 2048; i++) ref_mem[i] = init_val(i);
        RESET = 1'b1; VID_REQ = 1'b0; VID_A = '0;
        CPU_REQ = 1'b0; CPU_WE = 1'b0; CPU_A = '0; CPU_WDATA = '0;

        for (int i = 0; i < 3; i++) drive_cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, '0, '0);
        idle_cycles(2);

        // Video latency and hold
        drive_cycle(1'b1, 11'h040, 1'b0, 1'b0, 1'b0, '0, '0);
        s = cyc;
        idle_cycles(10);
        chk(cyc == s + 10 && VID_DATA == 8'h41, "vid_hold_t10", int'(VID_DATA), 'h41);

        // CPU write then read of the top address
        base_acks = n_acks;
        drive_cycle(1'b0, '0, 1'b0, 1'b1, 1'b1, 11'h7FF, 8'h5A);
        s = cyc;
        idle_cycles(2);
        drive_cycle(1'b0, '0, 1'b0, 1'b1, 1'b0, 11'h7FF, 8'h00);
        idle_cycles(5);
        chk(prev_ack == s + 2, "cpu_write_ack_cycle", prev_ack - s, 2);
        chk(last_ack == s + 5, "cpu_read_ack_cycle", last_ack - s, 5);
        chk(last_rdata == 8'h5A, "cpu_read_back", int'(last_rdata), 'h5A);
        chk(n_acks == base_acks + 2, "cpu_wr_rd_acks", n_acks - base_acks, 2);

        // Collision: video cycles 0..3, CPU read raised at cycle 1
        base_valid = n_valid;
        drive_cycle(1'b1, 11'h100, 1'b0, 1'b0, 1'b0, '0, '0);
        s = cyc;
        drive_cycle(1'b1, 11'h101, 1'b0, 1'b1, 1'b0, 11'h222, '0);
        drive_cycle(1'b1, 11'h102, 1'b0, 1'b0, 1'b0, '0, '0);
        drive_cycle(1'b1, 11'h103, 1'b0, 1'b0, 1'b0, '0, '0);
        idle_cycles(5);
        chk(last_ack == s + 6, "collision_ack_cycle", last_ack - s, 6);
        chk(n_valid == base_valid + 4, "collision_vid_valids", n_valid - base_valid, 4);

        // Starvation: video saturated, CPU read raised at cycle 0
        base_acks = n_acks;
        drive_cycle(1'b1, 11'h300, 1'b0, 1'b1, 1'b0, 11'h055, '0);
        s = cyc;
        for (int i = 1; i < 12; i++) drive_cycle(1'b1, 11'(11'h300 + i), 1'b0, 1'b0, 1'b0, '0, '0);
        drive_cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, '0);
        if (GUARD) begin
            chk(last_ack == s + 5, "starve_ack_cycle", last_ack - s, 5);
            chk(miss_cyc == s + 5, "starve_miss_cycle", miss_cyc - s, 5);
        end else begin
            chk(n_acks == base_acks, "starve_no_ack", n_acks - base_acks, 0);
        end
        idle_cycles(4);

        // Reset one cycle after a CPU grant
        base_acks = n_acks;
        drive_cycle(1'b0, '0, 1'b0, 1'b1, 1'b0, 11'h123, '0);
        drive_cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, '0, '0);
        idle_cycles(3);
        chk(n_acks == base_acks, "reset_drops_ack", n_acks - base_acks, 0);
        drive_cycle(1'b0, '0, 1'b0, 1'b1, 1'b0, 11'h124, '0);
        idle_cycles(4);
        chk(n_acks == base_acks + 1, "post_reset_ack", n_acks - base_acks, 1);

        // Back-to-back CPU requests held across ACK
        for (int i = 0; i < 8; i++)
            drive_cycle(1'b0, '0, 1'b0, 1'b1, 1'($urandom), 11'($urandom), 8'($urandom));
        idle_cycles(3);
        chk(last_ack - prev_ack == 3, "back_to_back_spacing", last_ack - prev_ack, 3);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 600; i++)
            drive_cycle($urandom_range(0, 3) != 0, 11'($urandom), $urandom_range(0, 199) == 0,
                        $urandom_range(0, 2) == 0, 1'($urandom), 11'($urandom), 8'($urandom));
        idle_cycles(6);
        chk(vq.size() + cq.size() + mq.size() == 0, "queues_drained", vq.size() + cq.size() + mq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
